// File: rtl/fg_handshake_tx.sv
// Initiator side of a 4-phase req/ack handshake carrying one word to an asynchronous receiver.
// The acknowledge is synchronized locally; an optional timeout aborts a handshake the receiver never answers.
module fg_handshake_tx #(
    parameter int DATA_WIDTH     = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  req_o,
    input  logic                  ack_i,
    output logic                  done_o,
    output logic                  timeout_o
);

    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam int CNT_W = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2
    } state_t;

    state_t                  state_reg, state_next;
    logic [DATA_WIDTH-1:0]   data_reg, data_next;
    logic                    req_reg, req_next;
    logic                    done_reg, done_next;
    logic                    timeout_reg, timeout_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next, cnt_inc;
    logic [SYNC_STAGES-1:0]  ack_sync_reg, ack_sync_next;
    logic                    ack_s;
    logic                    timeout_hit;

    // Acknowledge synchronizer: stage 0 samples the asynchronous input, each later stage the one before.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign ack_sync_next[gi] = ack_i;
            end else begin : g_rest
                assign ack_sync_next[gi] = ack_sync_reg[gi-1];
            end
        end
    endgenerate

    assign ack_s = ack_sync_reg[SYNC_STAGES-1];

    // With the timeout disabled the counter stays frozen at zero and never matches.
    generate
        if (TO_EN) begin : g_cnt_on
            assign cnt_inc     = cnt_reg + CNT_W'(1);
            assign timeout_hit = (cnt_reg == CNT_LAST);
        end else begin : g_cnt_off
            assign cnt_inc     = '0;
            assign timeout_hit = 1'b0;
        end
    endgenerate

    assign ready_o   = (state_reg == IDLE) && !ack_s;
    assign data_o    = data_reg;
    assign req_o     = req_reg;
    assign done_o    = done_reg;
    assign timeout_o = timeout_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            data_reg     <= '0;
            req_reg      <= 1'b0;
            done_reg     <= 1'b0;
            timeout_reg  <= 1'b0;
            cnt_reg      <= '0;
            ack_sync_reg <= '0;
        end else begin
            state_reg    <= state_next;
            data_reg     <= data_next;
            req_reg      <= req_next;
            done_reg     <= done_next;
            timeout_reg  <= timeout_next;
            cnt_reg      <= cnt_next;
            ack_sync_reg <= ack_sync_next;
        end
    end

    // A settled acknowledge wins over a timeout that would fire in the same cycle.
    always_comb begin
        state_next   = state_reg;
        data_next    = data_reg;
        req_next     = req_reg;
        cnt_next     = cnt_reg;
        done_next    = 1'b0;
        timeout_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (valid_i && ready_o) begin
                    data_next  = data_i;
                    req_next   = 1'b1;
                    cnt_next   = '0;
                    state_next = REQ_HI;
                end
            end
            REQ_HI: begin
                if (ack_s) begin
                    req_next   = 1'b0;
                    cnt_next   = '0;
                    state_next = REQ_LO;
                end else if (timeout_hit) begin
                    req_next     = 1'b0;
                    timeout_next = 1'b1;
                    state_next   = IDLE;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            REQ_LO: begin
                if (!ack_s) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else if (timeout_hit) begin
                    timeout_next = 1'b1;
                    state_next   = IDLE;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            default: begin
                state_next = IDLE;
                req_next   = 1'b0;
            end
        endcase
    end

endmodule
